// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Sequencer state: normal issue, whole-pipe freeze on dmem wait, timeout lockout.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  // Per-stage register controls, in pipeline order.
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
  } stage_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Everything held, nothing flushed.
  localparam stage_ctrl_t CTRL_HOLD = '{default: 1'b0};

  // Normal advance.
  localparam stage_ctrl_t CTRL_RUN = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b0,
                                       id_ex_we: 1'b1, id_ex_flush: 1'b0,
                                       ex_mem_we: 1'b1, mem_wb_we: 1'b1};

  // Taken branch: PC loads the target, the two younger instructions are squashed.
  localparam stage_ctrl_t CTRL_BRANCH = '{pc_we: 1'b1, if_id_we: 1'b1, if_id_flush: 1'b1,
                                          id_ex_we: 1'b1, id_ex_flush: 1'b1,
                                          ex_mem_we: 1'b1, mem_wb_we: 1'b1};

  // Load-use: hold PC and IF/ID, drop one bubble into EX.
  localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_we: 1'b0, if_id_we: 1'b0, if_id_flush: 1'b0,
                                            id_ex_we: 1'b1, id_ex_flush: 1'b1,
                                            ex_mem_we: 1'b1, mem_wb_we: 1'b1};

  // Fetch not ready: hold PC, feed a NOP into ID, let the rest drain.
  localparam stage_ctrl_t CTRL_IMEM_WAIT = '{pc_we: 1'b0, if_id_we: 1'b1, if_id_flush: 1'b1,
                                             id_ex_we: 1'b1, id_ex_flush: 1'b0,
                                             ex_mem_we: 1'b1, mem_wb_we: 1'b1};

  // A load in EX whose destination is read by ID; loads to x0 never hazard.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic [4:0] rs2,
                                    input logic       uses_rs1,
                                    input logic       uses_rs2);
    return mem_read && (rd != REG_X0) &&
           ((uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;

  // Count one per inc cycle until saturated; synchronous clear.
  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (inc && (value_q != {W{1'b1}})) begin
      value_q <= value_q + W'(1);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: merges dmem wait,
// taken branch, load-use and imem wait into one set of stage controls.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int MAX_MEM_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt
);

  // Last FREEZE cycle tolerated; still busy here means timeout.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_MEM_WAIT - 1);

  state_e      state_q;
  logic [7:0]  wait_q;
  logic        err_q;
  stage_ctrl_t ctrl;
  logic        lu;
  logic        flush_ev;
  logic        lu_ev;

  assign lu = load_use(ex_mem_read, ex_rd, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2);

  // Sequencer: freeze on dmem wait, count its length, lock into ERROR on timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          wait_q <= '0;
          if (dmem_busy) state_q <= FREEZE;
        end
        FREEZE: begin
          if (!dmem_busy) begin
            state_q <= RUN;
            wait_q  <= '0;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ERROR;
            err_q   <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ERROR: ;
        default: state_q <= RUN;
      endcase
    end
  end

  // Stage controls in priority order; FREEZE with dmem idle resolves like RUN.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    ctrl     = CTRL_HOLD;
    flush_ev = 1'b0;
    lu_ev    = 1'b0;
    if (!reset && (state_q != ERROR) && !dmem_busy) begin
      if (branch_taken) begin
        ctrl     = CTRL_BRANCH;
        flush_ev = 1'b1;
      end else if (lu) begin
        ctrl  = CTRL_LOAD_USE;
        lu_ev = 1'b1;
      end else if (imem_busy) begin
        ctrl = CTRL_IMEM_WAIT;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign if_id_we    = ctrl.if_id_we;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_we    = ctrl.id_ex_we;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign ex_mem_we   = ctrl.ex_mem_we;
  assign mem_wb_we   = ctrl.mem_wb_we;
  assign timeout_err = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!reset && !ctrl.pc_we),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_ev),
    .value (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (lu_ev),
    .value (lu_cnt)
  );

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Combines four sources into one consistent set of per-stage write-enable and flush controls, applied in a single priority order: data-memory busy, branch taken in EX, load-use hazard in ID, and instruction-memory busy.
- Tracks memory-wait duration for a timeout error and keeps saturating performance counters.
- Sits beside the pipeline registers; the forwarding units remain separate.

Parameters:
- CNT_W, 16, width of each saturating performance counter.
- MAX_MEM_WAIT, 64, consecutive dmem_busy cycles allowed before timeout; legal range 1..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- branch_taken  in  1  branch/jump resolved taken in EX
- imem_busy  in  1  instruction fetch not ready this cycle
- dmem_busy  in  1  data memory access not complete this cycle
- pc_we  out  1  PC register update enable
- if_id_we  out  1  IF/ID register write enable
- if_id_flush  out  1  load a NOP into IF/ID
- id_ex_we  out  1  ID/EX register write enable
- id_ex_flush  out  1  load a bubble into ID/EX
- ex_mem_we  out  1  EX/MEM register write enable
- mem_wb_we  out  1  MEM/WB register write enable
- timeout_err  out  1  sticky memory-wait timeout flag
- stall_cnt  out  CNT_W  cycles with pc_we=0
- flush_cnt  out  CNT_W  taken-branch flush events
- lu_cnt  out  CNT_W  load-use bubbles inserted

Behaviour:
- Reset:
  - Synchronous, active-high, on clk.
  - While reset is high: all *_we=0, both flushes=0.
  - After the reset edge: state=RUN, timeout_err=0, all counters=0, wait counter=0.
- Control outputs are combinational from the current state and inputs, so they take effect at the same clk edge. State and counters are registered.
- Load-use hazard (lu): ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). A load to x0 never stalls.
- Default in RUN with no event: all *_we=1, flushes=0.
- Priority in RUN, highest first:
  1. dmem_busy: all *_we=0, flushes=0; the whole pipe freezes. branch_taken and lu are ignored this cycle and re-evaluated when unfrozen, because EX/ID contents are held.
  2. branch_taken: pc_we=1 (target loads), if_id_flush=1, id_ex_flush=1, other *_we=1. A concurrent lu or imem_busy is ignored.
  3. lu: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1. Exactly one bubble; next cycle the load is in MEM and lu is false.
  4. imem_busy: pc_we=0, if_id_flush=1 (NOP into ID), downstream *_we=1.
- A flush takes precedence over that register's write enable.
- FSM states: RUN, FREEZE, ERROR.
  - RUN -> FREEZE on dmem_busy.
  - In FREEZE, outputs are as case 1 while dmem_busy=1.
  - FREEZE -> RUN on the first cycle dmem_busy=0; that cycle is evaluated with the RUN priority rules.
- Wait counter (8 bit): clears in RUN, increments each FREEZE cycle.
  - When dmem_busy is still high after MAX_MEM_WAIT FREEZE cycles -> ERROR, timeout_err=1.
  - ERROR: all *_we=0, flushes=0, held until reset.
- Counters saturate at all-ones and never wrap.
  - stall_cnt increments every non-reset cycle with pc_we=0.
  - flush_cnt increments on each RUN cycle applying case 2.
  - lu_cnt increments on each case 3 cycle.
- Reset asserted mid-freeze or in ERROR returns to RUN on the next edge with no pending event retained.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state enum (RUN, FREEZE, ERROR)
  - a stage-control struct bundling the seven we/flush bits
  - constant REG_X0=5'd0
- One natural sub-module, sat_counter (parameter W, inputs clk/reset/inc, output value), instantiated three times.

Test Plan:
- lu on rs1: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all we=1; lu_cnt=1.
- x0 load: ex_rd=0, id_rs1=0, id_uses_rs1=1 -> no stall, lu_cnt stays 0.
- Branch and lu together: branch_taken=1 with lu true -> if_id_flush=1, id_ex_flush=1, pc_we=1; flush_cnt=1, lu_cnt=0.
- Freeze: dmem_busy high 3 cycles with branch_taken=1 -> all we=0 for 3 cycles. Fourth cycle applies the flush; stall_cnt=3, flush_cnt=1.
- Timeout with MAX_MEM_WAIT=4: dmem_busy held high -> timeout_err=1 after 4 FREEZE cycles. It stays 1 after dmem_busy drops; a reset pulse clears it and returns to RUN.
- Saturation with CNT_W=4: 20 imem_busy cycles -> stall_cnt=15 and it holds.
